// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//
// Direct-mapped branch target buffer for the fetch stage. A lookup on the
// current fetch PC reports, in the same cycle, whether that PC holds a branch
// predicted taken and supplies its target. The table is trained from the EX
// stage with the resolved branch outcome, using a 2-bit saturating counter
// per entry. After reset or a flush, an internal sweep invalidates one entry
// per cycle. The table is usable (o_ready) only once the sweep has finished.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   i_lookup_valid  fetch PC valid this cycle
//   i_lookup_pc     fetch PC
//   o_hit           predicted-taken branch at i_lookup_pc
//   o_target        predicted target (zero when o_hit is low)
//   i_upd_valid     EX conditional-branch result valid
//   i_upd_pc        PC of the resolved branch
//   i_upd_target    resolved taken-target
//   i_upd_outcome   TAKEN / NOT_TAKEN
//   i_flush_all     invalidate every entry by restarting the sweep
//   o_ready         sweep complete, table usable
// ---------------------------------------------------------------------------

package mips_core_pkg;
   typedef enum logic {
      NOT_TAKEN = 1'b0,
      TAKEN     = 1'b1
   } BranchOutcome;
endpackage

module branch_target_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int INDEX_BITS = 6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_lookup_valid,
   input  logic [ADDR_WIDTH-1:0]       i_lookup_pc,
   output logic                        o_hit,
   output logic [ADDR_WIDTH-1:0]       o_target,
   input  logic                        i_upd_valid,
   input  logic [ADDR_WIDTH-1:0]       i_upd_pc,
   input  logic [ADDR_WIDTH-1:0]       i_upd_target,
   input  mips_core_pkg::BranchOutcome i_upd_outcome,
   input  logic                        i_flush_all,
   output logic                        o_ready
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t                  state_q, state_d;
   logic [INDEX_BITS-1:0]   sweep_idx_q, sweep_idx_d;
   logic                    clear_en;

   logic                    valid_q  [ENTRIES];
   logic [TAG_BITS-1:0]     tag_q    [ENTRIES];
   logic [ADDR_WIDTH-1:0]   target_q [ENTRIES];
   logic [1:0]              ctr_q    [ENTRIES];

   logic [INDEX_BITS-1:0]   lookup_idx;
   logic [TAG_BITS-1:0]     lookup_tag;
   logic [INDEX_BITS-1:0]   upd_idx;
   logic [TAG_BITS-1:0]     upd_tag;

   logic                    upd_allowed;
   logic                    upd_hit;
   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_target;
   logic [1:0]              wr_ctr;

   // The two low PC bits never select anything: instructions are word aligned.
   logic                    unused_pc_bits;
   assign unused_pc_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

   assign lookup_idx = i_lookup_pc[INDEX_BITS+1:2];
   assign lookup_tag = i_lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
   assign upd_idx    = i_upd_pc[INDEX_BITS+1:2];
   assign upd_tag    = i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];

   assign o_ready    = (state_q == RUN);

   // State register for the invalidation sweep. Reset parks the sweep at
   // entry 0 without clearing anything in the reset cycle itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         sweep_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
      end
   end

   // Sweep next-state logic. A flush restarts the sweep from entry 0 in any
   // state and, like reset, clears nothing in the cycle it is sampled. In
   // INIT each cycle clears the current entry; clearing the last entry hands
   // over to RUN.
   always_comb begin
      state_d     = state_q;
      sweep_idx_d = sweep_idx_q;
      clear_en    = 1'b0;
      if (i_flush_all) begin
         state_d     = INIT;
         sweep_idx_d = '0;
      end else begin
         case (state_q)
            INIT: begin
               clear_en    = !rst;
               sweep_idx_d = sweep_idx_q + 1'b1;
               if (sweep_idx_q == '1) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               state_d = RUN;
            end
            default: begin
               state_d = INIT;
            end
         endcase
      end
   end

   // Zero-latency lookup. Only the counter's upper bit predicts taken; an
   // entry sitting at a weak or strong not-taken count stays valid but
   // reports no hit. The target is forced to zero when there is no hit.
   always_comb begin
      o_hit    = 1'b0;
      o_target = '0;
      if ((state_q == RUN) && i_lookup_valid && valid_q[lookup_idx] &&
          (tag_q[lookup_idx] == lookup_tag) && ctr_q[lookup_idx][1]) begin
         o_hit    = 1'b1;
         o_target = target_q[lookup_idx];
      end
   end

   // Training logic. Updates are only accepted in RUN, and a simultaneous
   // flush or reset drops them. A tag hit moves the counter (and refreshes the
   // target on taken); a taken miss allocates over whatever was there with a
   // weakly-taken count; a not-taken miss leaves the table alone.
   always_comb begin
      upd_allowed = (state_q == RUN) && i_upd_valid && !i_flush_all && !rst;
      upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      wr_en       = 1'b0;
      wr_target   = target_q[upd_idx];
      wr_ctr      = ctr_q[upd_idx];
      if (upd_allowed) begin
         if (upd_hit) begin
            wr_en = 1'b1;
            if (i_upd_outcome == mips_core_pkg::TAKEN) begin
               wr_target = i_upd_target;
               if (ctr_q[upd_idx] != 2'b11) begin
                  wr_ctr = ctr_q[upd_idx] + 2'd1;
               end
            end else begin
               if (ctr_q[upd_idx] != 2'b00) begin
                  wr_ctr = ctr_q[upd_idx] - 2'd1;
               end
            end
         end else if (i_upd_outcome == mips_core_pkg::TAKEN) begin
            wr_en     = 1'b1;
            wr_target = i_upd_target;
            wr_ctr    = 2'b10;
         end
      end
   end

   // Valid bits: cleared by the sweep in INIT, set by training in RUN. The
   // two never happen in the same cycle because they belong to different
   // states.
   always_ff @(posedge clk) begin
      if (clear_en) begin
         valid_q[sweep_idx_q] <= 1'b0;
      end else if (wr_en) begin
         valid_q[upd_idx] <= 1'b1;
      end
   end

   // Entry payload. Not reset: an entry is meaningless until its valid bit is
   // set, and setting it always writes the payload too.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= wr_target;
         ctr_q[upd_idx]    <= wr_ctr;
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer
//
// Directed bench for branch_target_buffer with hand-computed expectations.
// Inputs are driven shortly after the falling edge and outputs sampled before
// the next rising edge. Index of a PC is pc[7:2], tag is pc[31:8].
// ---------------------------------------------------------------------------

module tb_branch_target_buffer;

   logic                        clk;
   logic                        rst;
   logic                        i_lookup_valid;
   logic [31:0]                 i_lookup_pc;
   logic                        o_hit;
   logic [31:0]                 o_target;
   logic                        i_upd_valid;
   logic [31:0]                 i_upd_pc;
   logic [31:0]                 i_upd_target;
   mips_core_pkg::BranchOutcome i_upd_outcome;
   logic                        i_flush_all;
   logic                        o_ready;

   int vectorsApplied = 0;
   int miscompares    = 0;

   branch_target_buffer #(
      .ADDR_WIDTH(32),
      .INDEX_BITS(6)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_lookup_valid (i_lookup_valid),
      .i_lookup_pc    (i_lookup_pc),
      .o_hit          (o_hit),
      .o_target       (o_target),
      .i_upd_valid    (i_upd_valid),
      .i_upd_pc       (i_upd_pc),
      .i_upd_target   (i_upd_target),
      .i_upd_outcome  (i_upd_outcome),
      .i_flush_all    (i_flush_all),
      .o_ready        (o_ready)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something stalls the sequence below.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no completion, expected completion before 200000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorsApplied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Advance one clock: past the rising edge to just after the falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Drive every DUT input at once.
   task automatic applyStimulus(input logic lv, input logic [31:0] lpc,
                                input logic uv, input logic [31:0] upc,
                                input logic [31:0] utgt,
                                input mips_core_pkg::BranchOutcome uout,
                                input logic flush);
      i_lookup_valid = lv;
      i_lookup_pc    = lpc;
      i_upd_valid    = uv;
      i_upd_pc       = upc;
      i_upd_target   = utgt;
      i_upd_outcome  = uout;
      i_flush_all    = flush;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, mips_core_pkg::NOT_TAKEN, 1'b0);
   endtask

   // One training update, committed at the next rising edge.
   task automatic doUpdate(input logic [31:0] pc, input logic [31:0] tgt,
                           input mips_core_pkg::BranchOutcome outcome);
      applyStimulus(1'b0, 32'h0, 1'b1, pc, tgt, outcome, 1'b0);
      step();
      idleInputs();
   endtask

   // Lookup with expected hit and target (target must read zero on a miss).
   task automatic doLookup(input string tag, input logic [31:0] pc,
                           input logic expHit, input logic [31:0] expTarget);
      applyStimulus(1'b1, pc, 1'b0, 32'h0, 32'h0, mips_core_pkg::NOT_TAKEN, 1'b0);
      #1;
      checkOutput({tag, "_hit"}, {31'b0, o_hit}, {31'b0, expHit});
      checkOutput({tag, "_target"}, o_target, expHit ? expTarget : 32'h0);
      idleInputs();
      step();
   endtask

   // Count cycles until o_ready while looking up pc, and count any hits seen
   // during the sweep. Bounded so a stuck sweep still reaches the summary.
   task automatic waitReady(input logic [31:0] pc, output int cycles, output int hits);
      cycles = 0;
      hits   = 0;
      i_lookup_valid = 1'b1;
      i_lookup_pc    = pc;
      #1;
      while (!o_ready && cycles < 200) begin
         if (o_hit) hits++;
         cycles++;
         step();
      end
      i_lookup_valid = 1'b0;
   endtask

   int cycles;
   int hits;

   initial begin
      rst = 1'b1;
      idleInputs();

      // Reset: two cycles held, outputs quiet even with a lookup presented.
      step();
      step();
      applyStimulus(1'b1, 32'h0040_0010, 1'b0, 32'h0, 32'h0, mips_core_pkg::NOT_TAKEN, 1'b0);
      #1;
      checkOutput("reset_ready", {31'b0, o_ready}, 32'h0);
      checkOutput("reset_hit", {31'b0, o_hit}, 32'h0);
      checkOutput("reset_target", o_target, 32'h0);
      rst = 1'b0;
      idleInputs();
      waitReady(32'h0040_0010, cycles, hits);
      checkOutput("reset_sweep_len", cycles, 64);
      checkOutput("reset_sweep_hits", hits, 0);
      checkOutput("ready_after_sweep", {31'b0, o_ready}, 32'h1);
      step();

      // Allocate and hit.
      doLookup("cold_miss", 32'h0040_0010, 1'b0, 32'h0);
      doUpdate(32'h0040_0010, 32'h0040_0100, mips_core_pkg::TAKEN);
      doLookup("alloc", 32'h0040_0010, 1'b1, 32'h0040_0100);

      // Counter hysteresis: 10 -> 01 -> 10 -> 11 (saturate) -> 10 -> 01 -> 00.
      doUpdate(32'h0040_0010, 32'h0, mips_core_pkg::NOT_TAKEN);
      doLookup("ctr01", 32'h0040_0010, 1'b0, 32'h0);
      doUpdate(32'h0040_0010, 32'h0040_0104, mips_core_pkg::TAKEN);
      doLookup("ctr10_newtgt", 32'h0040_0010, 1'b1, 32'h0040_0104);
      for (int i = 0; i < 3; i++) doUpdate(32'h0040_0010, 32'h0040_0104, mips_core_pkg::TAKEN);
      doLookup("ctr11", 32'h0040_0010, 1'b1, 32'h0040_0104);
      doUpdate(32'h0040_0010, 32'h0, mips_core_pkg::NOT_TAKEN);
      doLookup("nt1_ctr10", 32'h0040_0010, 1'b1, 32'h0040_0104);
      doUpdate(32'h0040_0010, 32'h0, mips_core_pkg::NOT_TAKEN);
      doLookup("nt2_ctr01", 32'h0040_0010, 1'b0, 32'h0);
      doUpdate(32'h0040_0010, 32'h0, mips_core_pkg::NOT_TAKEN);
      doLookup("nt3_ctr00", 32'h0040_0010, 1'b0, 32'h0);
      // Saturate at 00; entry stays valid so one TAKEN only reaches 01.
      doUpdate(32'h0040_0010, 32'h0, mips_core_pkg::NOT_TAKEN);
      doUpdate(32'h0040_0010, 32'h0040_0108, mips_core_pkg::TAKEN);
      doLookup("ctr00_stays_valid", 32'h0040_0010, 1'b0, 32'h0);
      doUpdate(32'h0040_0010, 32'h0040_0108, mips_core_pkg::TAKEN);
      doLookup("ctr_back_to_10", 32'h0040_0010, 1'b1, 32'h0040_0108);

      // Alias replacement at index 4.
      doUpdate(32'h0080_0010, 32'h0080_0200, mips_core_pkg::TAKEN);
      doLookup("alias_old", 32'h0040_0010, 1'b0, 32'h0);
      doLookup("alias_new", 32'h0080_0010, 1'b1, 32'h0080_0200);
      doUpdate(32'h00C0_0010, 32'h00C0_0300, mips_core_pkg::NOT_TAKEN);
      doLookup("alias_nt_keep", 32'h0080_0010, 1'b1, 32'h0080_0200);
      doLookup("alias_nt_noalloc", 32'h00C0_0010, 1'b0, 32'h0);
      doLookup("low_bits_ignored", 32'h0080_0013, 1'b1, 32'h0080_0200);

      // Same-cycle lookup and allocate: no bypass.
      applyStimulus(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0020, 32'h0040_0300,
                    mips_core_pkg::TAKEN, 1'b0);
      #1;
      checkOutput("same_cycle_hit", {31'b0, o_hit}, 32'h0);
      step();
      i_upd_valid = 1'b0;
      #1;
      checkOutput("next_cycle_hit", {31'b0, o_hit}, 32'h1);
      checkOutput("next_cycle_target", o_target, 32'h0040_0300);
      idleInputs();
      step();

      // Back-to-back updates accumulate: 10, 11, 10, 01.
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0040_0030, 32'h0040_0330, mips_core_pkg::TAKEN, 1'b0);
      step();
      step();
      i_upd_outcome = mips_core_pkg::NOT_TAKEN;
      step();
      step();
      idleInputs();
      doLookup("b2b_ctr01", 32'h0040_0030, 1'b0, 32'h0);
      doUpdate(32'h0040_0030, 32'h0040_0330, mips_core_pkg::TAKEN);
      doLookup("b2b_ctr10", 32'h0040_0030, 1'b1, 32'h0040_0330);

      // Flush with four live entries and a concurrent update.
      doUpdate(32'h0040_0040, 32'h0040_0400, mips_core_pkg::TAKEN);
      doLookup("pre_flush", 32'h0040_0040, 1'b1, 32'h0040_0400);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0040_0050, 32'h0040_0500, mips_core_pkg::TAKEN, 1'b1);
      step();
      idleInputs();
      waitReady(32'h0080_0010, cycles, hits);
      checkOutput("flush_sweep_len", cycles, 64);
      checkOutput("flush_sweep_hits", hits, 0);
      step();
      doLookup("flushed_a", 32'h0080_0010, 1'b0, 32'h0);
      doLookup("flushed_b", 32'h0040_0020, 1'b0, 32'h0);
      doLookup("flushed_c", 32'h0040_0030, 1'b0, 32'h0);
      doLookup("flushed_d", 32'h0040_0040, 1'b0, 32'h0);
      doLookup("flush_upd_dropped", 32'h0040_0050, 1'b0, 32'h0);

      // Flush mid-sweep restarts the count; an update during INIT is dropped
      // (issued after the sweep has passed its index so it would survive).
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, mips_core_pkg::NOT_TAKEN, 1'b1);
      step();
      idleInputs();
      repeat (20) step();
      i_flush_all = 1'b1;
      step();
      i_flush_all = 1'b0;
      repeat (40) step();
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0040_0060, 32'h0040_0600, mips_core_pkg::TAKEN, 1'b0);
      step();
      idleInputs();
      waitReady(32'h0, cycles, hits);
      checkOutput("flush_restart_len", 41 + cycles, 64);
      step();
      doLookup("init_upd_dropped", 32'h0040_0060, 1'b0, 32'h0);

      // Reset at sweep cycle 30 restarts the full 64-cycle sweep.
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, mips_core_pkg::NOT_TAKEN, 1'b1);
      step();
      idleInputs();
      repeat (30) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      waitReady(32'h0, cycles, hits);
      checkOutput("rst_restart_len", cycles, 64);
      step();

      // Table usable again after the restarted sweep.
      doUpdate(32'h0100_00FC, 32'h0100_1000, mips_core_pkg::TAKEN);
      doLookup("post_sweep_alloc", 32'h0100_00FC, 1'b1, 32'h0100_1000);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
